// File: rtl/exec_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exec_ctrl_pkg : command codes and state encoding for the execution sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
package exec_ctrl_pkg;

   localparam int C_CMD_BITS    = 3;

   localparam int C_CMD_RUN     = 1;
   localparam int C_CMD_STEP    = 2;
   localparam int C_CMD_STOP    = 3;
   localparam int C_CMD_RESTART = 4;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START_RUN  = 3'd1,
      ST_START_STEP = 3'd2,
      ST_RUN        = 3'd3,
      ST_PAUSED     = 3'd4,
      ST_STEP       = 3'd5,
      ST_HALTED     = 3'd6
   } state_e;

endpackage
`default_nettype wire

// File: rtl/exec_ctrl_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter : saturating up-counter with synchronous clear and increment enable
// Revision 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Clear has priority so a start pulse always restarts counting from zero
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/exec_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exec_ctrl : debug-command driven run/step/stop/restart sequencer for the pipeline
// Revision 1.0
// ----------------------------------------------------------------------------
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int CYCLE_COUNTER_BITS = 32,
   parameter int CMD_BITS           = C_CMD_BITS
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_cmd_valid,
   input  logic [CMD_BITS-1:0]           i_cmd,
   output logic                          o_cmd_ready,
   output logic                          o_cmd_err,
   input  logic                          i_halt_wb,
   output logic                          o_start,
   output logic                          o_enable,
   output logic                          o_halt,
   output logic                          o_step_done,
   output logic [2:0]                    o_state,
   output logic [CYCLE_COUNTER_BITS-1:0] o_cycle_count
);

   localparam logic [CMD_BITS-1:0] C_RUN     = CMD_BITS'(C_CMD_RUN);
   localparam logic [CMD_BITS-1:0] C_STEP    = CMD_BITS'(C_CMD_STEP);
   localparam logic [CMD_BITS-1:0] C_STOP    = CMD_BITS'(C_CMD_STOP);
   localparam logic [CMD_BITS-1:0] C_RESTART = CMD_BITS'(C_CMD_RESTART);

   state_e state_q;
   state_e state_d;
   logic   cmd_err_q;
   logic   cmd_err_d;
   logic   step_done_q;
   logic   step_done_d;

   logic   w_ready;
   logic   w_start;
   logic   w_enable;
   logic   w_halt;
   logic   w_take;

   assign w_take = i_cmd_valid & w_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         cmd_err_q   <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_err_q   <= cmd_err_d;
         step_done_q <= step_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_err_d   = 1'b0;
      step_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_take) begin
               if (i_cmd == C_RUN)       state_d   = ST_START_RUN;
               else if (i_cmd == C_STEP) state_d   = ST_START_STEP;
               else                      cmd_err_d = 1'b1;
            end
         end
         ST_START_RUN:  state_d = ST_RUN;
         ST_START_STEP: state_d = ST_PAUSED;
         ST_RUN: begin
            // A retiring HALT overrides any command taken in the same cycle
            if (i_halt_wb) begin
               state_d   = ST_HALTED;
               cmd_err_d = w_take;
            end else if (w_take) begin
               if (i_cmd == C_STOP)         state_d   = ST_PAUSED;
               else if (i_cmd == C_RESTART) state_d   = ST_START_RUN;
               else                         cmd_err_d = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (w_take) begin
               if (i_cmd == C_STEP)         state_d   = ST_STEP;
               else if (i_cmd == C_RUN)     state_d   = ST_RUN;
               else if (i_cmd == C_RESTART) state_d   = ST_START_STEP;
               else                         cmd_err_d = 1'b1;
            end
         end
         ST_STEP: begin
            step_done_d = 1'b1;
            state_d     = i_halt_wb ? ST_HALTED : ST_PAUSED;
         end
         ST_HALTED: begin
            if (w_take) begin
               if (i_cmd == C_RESTART) state_d   = ST_START_RUN;
               else                    cmd_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready  = 1'b0;
      w_start  = 1'b0;
      w_enable = 1'b0;
      w_halt   = 1'b0;
      case (state_q)
         ST_IDLE, ST_PAUSED:           w_ready  = 1'b1;
         ST_START_RUN, ST_START_STEP:  w_start  = 1'b1;
         ST_RUN: begin
            w_ready  = 1'b1;
            w_enable = 1'b1;
         end
         ST_STEP:                      w_enable = 1'b1;
         ST_HALTED: begin
            w_ready  = 1'b1;
            w_halt   = 1'b1;
         end
         default: w_ready = 1'b0;
      endcase
   end

   sat_counter #(
      .WIDTH (CYCLE_COUNTER_BITS)
   ) u_cycle_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_start),
      .i_inc   (w_enable),
      .o_count (o_cycle_count)
   );

   assign o_cmd_ready = w_ready;
   assign o_cmd_err   = cmd_err_q;
   assign o_start     = w_start;
   assign o_enable    = w_enable;
   assign o_halt      = w_halt;
   assign o_step_done = step_done_q;
   assign o_state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_exec_ctrl : scoreboard bench for exec_ctrl (32-bit and 4-bit counter instances)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic        halt_wb;

   logic        cmd_ready, cmd_err, start, enable, halt, step_done;
   logic [2:0]  state;
   logic [31:0] count;

   logic        cmd_ready_4, cmd_err_4, start_4, enable_4, halt_4, step_done_4;
   logic [2:0]  state_4;
   logic [3:0]  count_4;

   int n_checks = 0;
   int n_fail   = 0;
   int n_start  = 0;
   int n_en     = 0;
   int n_sd     = 0;
   int n_err    = 0;

   logic [31:0] err_q  [$];
   logic [31:0] step_q [$];

   always #5 clk = ~clk;

   exec_ctrl #(.CYCLE_COUNTER_BITS(32), .CMD_BITS(3)) dut (
      .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
      .o_cmd_ready(cmd_ready), .o_cmd_err(cmd_err), .i_halt_wb(halt_wb),
      .o_start(start), .o_enable(enable), .o_halt(halt), .o_step_done(step_done),
      .o_state(state), .o_cycle_count(count)
   );

   exec_ctrl #(.CYCLE_COUNTER_BITS(4), .CMD_BITS(3)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
      .o_cmd_ready(cmd_ready_4), .o_cmd_err(cmd_err_4), .i_halt_wb(halt_wb),
      .o_start(start_4), .o_enable(enable_4), .o_halt(halt_4), .o_step_done(step_done_4),
      .o_state(state_4), .o_cycle_count(count_4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd       = 3'd0;
      halt_wb   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] c);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      if (!cmd_ready) check_eq("cmd_ready_timeout", {31'd0, cmd_ready}, 1);
      cmd_valid = 1'b1;
      cmd       = c;
      tick();
      cmd_valid = 1'b0;
      cmd       = 3'd0;
   endtask

   // Pulse monitor: pops the scoreboard whenever the DUT emits an error or step-done pulse
   always @(negedge clk) begin
      if (!rst) begin
         if (start)  n_start++;
         if (enable) n_en++;
         if (cmd_err) begin
            n_err++;
            if (err_q.size() > 0) check_eq("cmd_err_state", {29'd0, state}, err_q.pop_front());
            else                  check_eq("cmd_err_unexpected", {31'd0, cmd_err}, 0);
         end
         if (step_done) begin
            n_sd++;
            if (step_q.size() > 0) check_eq("step_done_count", count, step_q.pop_front());
            else                   check_eq("step_done_unexpected", {31'd0, step_done}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int s0, e0, d0, r0;
      do_reset();
      rst = 1'b1;
      #1;
      check_eq("rst_state", {29'd0, state}, 0);
      check_eq("rst_ready", {31'd0, cmd_ready}, 1);
      check_eq("rst_enable", {31'd0, enable}, 0);
      check_eq("rst_count", count, 0);
      rst = 1'b0;
      tick();

      // RUN then HALT retiring on the 10th enabled cycle
      do_reset();
      s0 = n_start; e0 = n_en;
      send_cmd(3'd1);
      check_eq("t1_start", {31'd0, start}, 1);
      tick();
      repeat (9) tick();
      halt_wb = 1'b1;
      tick();
      halt_wb = 1'b0;
      check_eq("t1_state", {29'd0, state}, 6);
      check_eq("t1_halt", {31'd0, halt}, 1);
      check_eq("t1_enable", {31'd0, enable}, 0);
      check_eq("t1_count", count, 10);
      check_eq("t1_nstart", 32'(n_start - s0), 1);
      check_eq("t1_nen", 32'(n_en - e0), 10);

      // STEP from IDLE, then three single steps
      do_reset();
      s0 = n_start; e0 = n_en; d0 = n_sd;
      send_cmd(3'd2);
      tick();
      for (int k = 1; k <= 3; k++) begin
         step_q.push_back(32'(k));
         send_cmd(3'd2);
         tick();
      end
      tick();
      check_eq("t2_state", {29'd0, state}, 4);
      check_eq("t2_count", count, 3);
      check_eq("t2_nstart", 32'(n_start - s0), 1);
      check_eq("t2_nen", 32'(n_en - e0), 3);
      check_eq("t2_nsd", 32'(n_sd - d0), 3);

      // RUN 5, STOP, idle 20, RUN 5 more
      do_reset();
      s0 = n_start; e0 = n_en;
      send_cmd(3'd1);
      tick();
      repeat (4) tick();
      send_cmd(3'd3);
      check_eq("t3_paused", {29'd0, state}, 4);
      check_eq("t3_count5", count, 5);
      repeat (20) tick();
      check_eq("t3_enable_paused", {31'd0, enable}, 0);
      check_eq("t3_count_hold", count, 5);
      send_cmd(3'd1);
      repeat (4) tick();
      send_cmd(3'd3);
      check_eq("t3_count10", count, 10);
      check_eq("t3_nstart", 32'(n_start - s0), 1);
      check_eq("t3_nen", 32'(n_en - e0), 10);

      // STOP collides with HALT, then STEP in HALTED, then RESTART
      do_reset();
      r0 = n_err;
      send_cmd(3'd1);
      tick();
      err_q.push_back(32'd6);
      halt_wb = 1'b1;
      send_cmd(3'd3);
      halt_wb = 1'b0;
      check_eq("t4_state", {29'd0, state}, 6);
      check_eq("t4_halt", {31'd0, halt}, 1);
      err_q.push_back(32'd6);
      send_cmd(3'd2);
      tick();
      check_eq("t4_state_after_step", {29'd0, state}, 6);
      check_eq("t4_nerr", 32'(n_err - r0), 2);
      send_cmd(3'd4);
      check_eq("t4_restart_start", {31'd0, start}, 1);
      check_eq("t4_restart_halt", {31'd0, halt}, 0);
      tick();
      check_eq("t4_restart_count", count, 0);
      check_eq("t4_restart_enable", {31'd0, enable}, 1);

      // Asynchronous reset between edges while running
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      check_eq("t5_enable", {31'd0, enable}, 0);
      check_eq("t5_start", {31'd0, start}, 0);
      check_eq("t5_halt", {31'd0, halt}, 0);
      check_eq("t5_state", {29'd0, state}, 0);
      check_eq("t5_count", count, 0);
      check_eq("t5_ready", {31'd0, cmd_ready}, 1);
      tick();
      rst = 1'b0;

      // Illegal code in IDLE, then saturation of the 4-bit instance
      do_reset();
      err_q.push_back(32'd0);
      send_cmd(3'd7);
      check_eq("t6_idle_after_illegal", {29'd0, state}, 0);
      tick();
      send_cmd(3'd1);
      tick();
      repeat (14) tick();
      check_eq("t6_cnt4_14", {28'd0, count_4}, 14);
      tick();
      check_eq("t6_cnt4_15", {28'd0, count_4}, 15);
      tick();
      check_eq("t6_cnt4_nowrap", {28'd0, count_4}, 15);
      check_eq("t6_cnt32_16", count, 16);
      repeat (4) tick();
      check_eq("t6_cnt4_sat", {28'd0, count_4}, 15);
      check_eq("t6_cnt32_20", count, 20);

      tick();
      check_eq("err_queue_drained", 32'(err_q.size()), 0);
      check_eq("step_queue_drained", 32'(step_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
Execution sequencer for the MIPS pipeline. It turns debug-unit commands (run, step, stop, restart) into the pc/pipeline control strobes: start pulse, enable level and halt level. It detects program end when a HALT instruction retires, and counts enabled cycles. It sits between the debug/UART command decoder and the pipeline top, and drives pc.i_start, pc.i_halt and the pipeline-wide i_enable.

Parameters:
CYCLE_COUNTER_BITS, 32, width of the enabled-cycle counter
CMD_BITS, 3, width of the command code

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_cmd_valid  in  1  command present
i_cmd  in  CMD_BITS  command code: 1=RUN, 2=STEP, 3=STOP, 4=RESTART; others illegal
o_cmd_ready  out  1  command accepted this cycle when valid & ready
o_cmd_err  out  1  1-cycle pulse: accepted command illegal in current state
i_halt_wb  in  1  HALT instruction retired in WB this cycle
o_start  out  1  1-cycle pulse to pc/pipeline: PC <- 0, clear pipeline
o_enable  out  1  pipeline/PC advance enable
o_halt  out  1  level to pc: frozen by program end
o_step_done  out  1  1-cycle pulse after a STEP cycle completes
o_state  out  3  encoded current state, for the debug readout
o_cycle_count  out  CYCLE_COUNTER_BITS  number of cycles with o_enable=1 since the last o_start

Behaviour:
- States: IDLE=0, START_RUN=1, START_STEP=2, RUN=3, PAUSED=4, STEP=5, HALTED=6.
- Reset (async, any time, including mid-RUN or mid-STEP):
  - state=IDLE; all outputs 0 except o_cmd_ready=1; o_cycle_count=0.
- o_cmd_ready=1 in IDLE, RUN, PAUSED and HALTED; 0 in START_RUN, START_STEP and STEP.
- A command is consumed on the edge where i_cmd_valid & o_cmd_ready.
- Legal transitions; every other consumed command pulses o_cmd_err the next cycle with no state change:
  - IDLE: RUN->START_RUN; STEP->START_STEP.
  - START_RUN: o_start=1 for this one cycle, counter cleared; next state RUN.
  - START_STEP: o_start=1, counter cleared; next state PAUSED.
  - RUN: o_enable=1. STOP->PAUSED. i_halt_wb->HALTED. RESTART->START_RUN.
  - PAUSED: o_enable=0. STEP->STEP. RUN->RUN, with no start pulse. RESTART->START_STEP.
  - STEP: o_enable=1 for exactly one cycle; next state PAUSED, with o_step_done=1 during the first PAUSED cycle. If i_halt_wb=1 in STEP, go to HALTED and pulse o_step_done as well.
  - HALTED: o_halt=1, o_enable=0. RESTART->START_RUN. RUN and STEP give o_cmd_err.
- Simultaneous events:
  - i_halt_wb and a STOP/RESTART consumed in the same RUN cycle: halt wins, state=HALTED, and the command is reported via o_cmd_err.
  - i_halt_wb is ignored outside RUN and STEP.
- o_enable is registered and decoded from state, so the first enabled cycle is the cycle after entry into RUN or STEP. Latency is 1 cycle from command acceptance to state entry.
- Counter:
  - increments on each cycle with o_enable=1;
  - saturates at 2^CYCLE_COUNTER_BITS-1, with no wrap;
  - cleared only by reset or by o_start.
- o_halt drops on the cycle o_start is asserted after a RESTART.

Decomposition:
- Shared package/header: command codes, state encodings, CMD_BITS default.
- One natural sub-module: sat_counter, a parameterised saturating counter with clear and increment enable, reused for o_cycle_count.

Test Plan:
- Reset, then RUN, then i_halt_wb after 10 enabled cycles -> o_start pulses once; o_enable high for exactly 10 cycles; state=HALTED; o_halt=1; o_cycle_count=10.
- STEP from IDLE, then 3 STEP commands -> one o_start; 3 o_step_done pulses; each with exactly one o_enable cycle; o_cycle_count=3; state=PAUSED.
- RUN, STOP after 5 cycles, wait 20 cycles, RUN for 5 more -> o_enable low while PAUSED; no second o_start; o_cycle_count=10.
- RUN and STOP presented in the same cycle as i_halt_wb -> state=HALTED; o_cmd_err pulses once. Then STEP in HALTED -> o_cmd_err; RESTART -> o_start pulse, o_halt=0, o_cycle_count=0.
- Async reset asserted mid-RUN, between clock edges -> o_enable, o_start and o_halt drop immediately; state=IDLE; counter=0.
- CYCLE_COUNTER_BITS=4, RUN for 20 cycles -> o_cycle_count saturates at 15. Also drive illegal code 7 in IDLE -> o_cmd_err pulse, state stays IDLE.
